// File: rtl/matrix_sequencer.sv
// Control FSM for the matrix processor: one matrix load, then per work item a
// vector load, multiply-accumulate pass, optional perspective divide and writeback.
module matrix_sequencer #(
    parameter int DIM   = 4,
    parameter int WI_W  = 16,
    parameter int CNT_W = $clog2(DIM*DIM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WI_W-1:0]  wi_count,
    input  logic             persp_en,
    input  logic             abort,
    input  logic             div_done,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] elem_idx,
    output logic             load_matrix,
    output logic             load_vector,
    output logic             read_addr_src,
    output logic             fma_en,
    output logic             acc_write_en,
    output logic             start_div,
    output logic             write_en,
    output logic             wi_advance
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_MATRIX,
        LOAD_VECTOR,
        PROCESS,
        START_DIV,
        WAIT_DIV,
        WRITE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ELEM = CNT_W'(DIM*DIM - 1);
    localparam logic [CNT_W-1:0] LAST_COL  = CNT_W'(DIM - 1);
    localparam logic [CNT_W-1:0] DIM_C     = CNT_W'(DIM);

    state_t          state;
    state_t          stateNext;
    logic [WI_W-1:0] remaining;
    logic            perspMode;
    logic            doneNext;
    logic            lastWrite;
    logic            rowEnd;
    logic            counting;
    logic            accept;

    assign lastWrite = (state == WRITE) && (elem_idx == LAST_COL);
    assign rowEnd    = (elem_idx % DIM_C) == LAST_COL;
    assign counting  = (state == LOAD_MATRIX) || (state == LOAD_VECTOR) ||
                       (state == PROCESS) || (state == WRITE);
    assign accept    = (state == IDLE) && start && (wi_count != '0);

    always_comb begin
        stateNext = state;
        doneNext  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (wi_count != '0) stateNext = LOAD_MATRIX;
                    else                doneNext  = 1'b1;
                end
            end
            LOAD_MATRIX: if (elem_idx == LAST_ELEM) stateNext = LOAD_VECTOR;
            LOAD_VECTOR: if (elem_idx == LAST_COL)  stateNext = PROCESS;
            PROCESS: begin
                if (elem_idx == LAST_ELEM) stateNext = perspMode ? START_DIV : WRITE;
            end
            START_DIV: stateNext = WAIT_DIV;
            WAIT_DIV:  if (div_done) stateNext = WRITE;
            WRITE: begin
                if (lastWrite) begin
                    if (remaining == WI_W'(1)) begin
                        stateNext = IDLE;
                        doneNext  = 1'b1;
                    end else begin
                        stateNext = LOAD_VECTOR;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
        // abort overrides every transition, including completion
        if (abort && (state != IDLE)) begin
            stateNext = IDLE;
            doneNext  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            elem_idx  <= '0;
            remaining <= '0;
            perspMode <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= stateNext;
            done  <= doneNext;
            if (stateNext != state) elem_idx <= '0;
            else if (counting)      elem_idx <= elem_idx + CNT_W'(1);
            if (accept) begin
                remaining <= wi_count;
                perspMode <= persp_en;
            end else if (lastWrite && !abort) begin
                remaining <= remaining - WI_W'(1);
            end
        end
    end

    always_comb begin
        busy          = (state != IDLE);
        load_matrix   = 1'b0;
        load_vector   = 1'b0;
        read_addr_src = 1'b0;
        fma_en        = 1'b0;
        acc_write_en  = 1'b0;
        start_div     = 1'b0;
        write_en      = 1'b0;
        wi_advance    = 1'b0;
        case (state)
            LOAD_MATRIX: load_matrix = 1'b1;
            LOAD_VECTOR: begin
                load_vector   = 1'b1;
                read_addr_src = 1'b1;
            end
            PROCESS: begin
                fma_en       = 1'b1;
                acc_write_en = rowEnd;
            end
            START_DIV: start_div = 1'b1;
            WRITE: begin
                write_en   = 1'b1;
                fma_en     = perspMode;
                wi_advance = lastWrite;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_matrix_sequencer.sv
// Scoreboard bench for matrix_sequencer: per-cycle expected output records are
// queued when a job is launched and compared at each falling edge.
module tb_matrix_sequencer;

    typedef logic [15:0] rec_t;

    localparam logic [7:0] S_LM  = 8'h80;
    localparam logic [7:0] S_LV  = 8'h40;
    localparam logic [7:0] S_RA  = 8'h20;
    localparam logic [7:0] S_FMA = 8'h10;
    localparam logic [7:0] S_ACC = 8'h08;
    localparam logic [7:0] S_SD  = 8'h04;
    localparam logic [7:0] S_WR  = 8'h02;
    localparam logic [7:0] S_ADV = 8'h01;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, persp, abort, divManual, divResp, divAuto, divDone;
    logic [15:0] wi;
    logic        start3, persp3;
    logic [15:0] wi3;

    logic       busy4, done4, lm4, lv4, ra4, fma4, acc4, sd4, wr4, adv4;
    logic [3:0] idx4;
    logic       busy3, done3, lm3, lv3, ra3, fma3, acc3, sd3, wr3, adv3;
    logic [3:0] idx3;
    rec_t       obs4, obs3;

    rec_t q4[$];
    rec_t q3[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign divDone = divResp | divManual;

    matrix_sequencer #(.DIM(4), .WI_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .wi_count(wi), .persp_en(persp),
        .abort(abort), .div_done(divDone), .busy(busy4), .done(done4),
        .elem_idx(idx4), .load_matrix(lm4), .load_vector(lv4),
        .read_addr_src(ra4), .fma_en(fma4), .acc_write_en(acc4),
        .start_div(sd4), .write_en(wr4), .wi_advance(adv4)
    );

    matrix_sequencer #(.DIM(3), .WI_W(16)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .wi_count(wi3), .persp_en(persp3),
        .abort(1'b0), .div_done(1'b0), .busy(busy3), .done(done3),
        .elem_idx(idx3), .load_matrix(lm3), .load_vector(lv3),
        .read_addr_src(ra3), .fma_en(fma3), .acc_write_en(acc3),
        .start_div(sd3), .write_en(wr3), .wi_advance(adv3)
    );

    assign obs4 = {busy4, done4, 6'(idx4), lm4, lv4, ra4, fma4, acc4, sd4, wr4, adv4};
    assign obs3 = {busy3, done3, 6'(idx3), lm3, lv3, ra3, fma3, acc3, sd3, wr3, adv3};

    task automatic checkVal(input string tag, input rec_t got, input rec_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic rec_t mk(input logic b, input logic d, input int idx, input logic [7:0] s);
        return {b, d, 6'(idx), s};
    endfunction

    task automatic pushRec(input int which, input rec_t r);
        if (which == 3) q3.push_back(r);
        else            q4.push_back(r);
    endtask

    // Expected cycle-by-cycle trace of a job; keep>=0 truncates it (abort/reset cases)
    task automatic pushJob(input int which, input int dim, input int n, input bit p,
                           input int divWait, input int keep);
        rec_t t[$];
        for (int i = 0; i < dim*dim; i++) t.push_back(mk(1, 0, i, S_LM));
        for (int v = 0; v < n; v++) begin
            for (int i = 0; i < dim; i++) t.push_back(mk(1, 0, i, S_LV | S_RA));
            for (int i = 0; i < dim*dim; i++)
                t.push_back(mk(1, 0, i, S_FMA | ((i % dim == dim-1) ? S_ACC : 8'h00)));
            if (p) begin
                t.push_back(mk(1, 0, 0, S_SD));
                for (int w = 0; w < divWait; w++) t.push_back(mk(1, 0, 0, 8'h00));
            end
            for (int i = 0; i < dim; i++)
                t.push_back(mk(1, 0, i, S_WR | (p ? S_FMA : 8'h00) | ((i == dim-1) ? S_ADV : 8'h00)));
        end
        t.push_back(mk(0, 1, 0, 8'h00));
        t.push_back(mk(0, 0, 0, 8'h00));
        for (int i = 0; i < t.size() && (keep < 0 || i < keep); i++) pushRec(which, t[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q4.size() > 0 || q3.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        checkVal("drainTimeout", 16'(q4.size() + q3.size()), 16'(0));
    endtask

    always @(negedge clk) begin
        if (q4.size() > 0) checkVal("dim4", obs4, q4.pop_front());
        if (q3.size() > 0) checkVal("dim3", obs3, q3.pop_front());
    end

    // divider model: result valid 3 cycles after the start_div pulse
    initial begin
        divResp = 1'b0;
        forever begin
            @(negedge clk);
            if (sd4 && divAuto) begin
                repeat (3) @(negedge clk);
                divResp = 1'b1;
                @(negedge clk);
                divResp = 1'b0;
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; wi = '0; persp = 1'b0; abort = 1'b0;
        divManual = 1'b0; divAuto = 1'b1;
        start3 = 1'b0; wi3 = '0; persp3 = 1'b0;
        tick();
        checkVal("reset4", obs4, 16'h0000);
        checkVal("reset3", obs3, 16'h0000);
        tick();
        rst = 1'b0;
        tick();

        // affine, one vector
        wi = 16'd1; persp = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        pushJob(4, 4, 1, 1'b0, 0, -1);
        drain(200);

        // perspective, two vectors; a start mid-job with new inputs is ignored
        wi = 16'd2; persp = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        pushJob(4, 4, 2, 1'b1, 3, -1);
        repeat (10) tick();
        start = 1'b1; wi = 16'd5; persp = 1'b0;
        tick();
        start = 1'b0;
        drain(300);

        // zero work items
        wi = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        pushRec(4, mk(0, 1, 0, 8'h00));
        pushRec(4, mk(0, 0, 0, 8'h00));
        pushRec(4, mk(0, 0, 0, 8'h00));
        drain(20);

        // abort while idle has no effect
        abort = 1'b1;
        tick();
        abort = 1'b0;
        pushRec(4, mk(0, 0, 0, 8'h00));
        pushRec(4, mk(0, 0, 0, 8'h00));
        drain(20);

        // start and abort together: start wins
        wi = 16'd1; persp = 1'b0; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        pushJob(4, 4, 1, 1'b0, 0, -1);
        drain(200);

        // abort in the second WAIT_DIV cycle, together with div_done
        divAuto = 1'b0;
        wi = 16'd1; persp = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        pushJob(4, 4, 1, 1'b1, 2, 39);
        for (int i = 0; i < 3; i++) pushRec(4, mk(0, 0, 0, 8'h00));
        repeat (38) tick();
        abort = 1'b1; divManual = 1'b1;
        tick();
        abort = 1'b0; divManual = 1'b0;
        drain(100);
        divAuto = 1'b1;

        // DIM=3 instance, affine
        wi3 = 16'd1; persp3 = 1'b0; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        pushJob(3, 3, 1, 1'b0, 0, -1);
        drain(100);

        // async reset in the middle of PROCESS, then a normal job
        wi = 16'd1; persp = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        pushJob(4, 4, 1, 1'b0, 0, 25);
        repeat (25) tick();
        rst = 1'b1;
        #1;
        checkVal("rstMidJob", obs4, 16'h0000);
        tick();
        rst = 1'b0;
        tick();
        wi = 16'd1; persp = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        pushJob(4, 4, 1, 1'b0, 0, -1);
        drain(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
